// File: rtl/jtframe_dump_sched.sv
// Capture-window scheduler: counts frames from vertical sync and opens a dump
// window either at a chosen frame number or when the ROM download ends (after
// a post-reset guard delay). The window closes after a programmed number of
// frames, when arm drops, or (download mode) when a new download starts.
//
// Handshake/pulse semantics: there is no valid/ready pair here; dump_start and
// dump_stop are single-cycle strobes registered together with the state, so
// dump_en, dump_start and dump_stop always agree with st in the same cycle.
module jtframe_dump_sched #(
  parameter int FW    = 32,
  parameter int LW    = 16,
  parameter int GUARD = 20000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vs,
  input  logic          dwnld,
  input  logic          arm,
  input  logic          mode_rom,
  input  logic [FW-1:0] start_frame,
  input  logic [LW-1:0] dump_len,
  output logic [FW-1:0] frame_cnt,
  output logic          dump_en,
  output logic          dump_start,
  output logic          dump_stop,
  output logic [1:0]    st
);

  localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Synchroniser chains: [0],[1] are the metastability flops, [2] is the
  // edge-detect history flop.
  logic [2:0]    vs_s_q;
  logic [2:0]    dl_s_q;
  logic          vs_fall;
  logic          dwnld_fall;
  logic          dwnld_rise;

  logic [FW-1:0] frame_cnt_q;
  logic [FW-1:0] frame_cnt_d;
  logic [GW-1:0] guard_q;
  logic          guard_ok;

  state_t        state_q, state_d;
  logic          mode_q, mode_d;
  logic [FW-1:0] start_q, start_d;
  logic [LW-1:0] dlen_q, dlen_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] len_next;
  logic          start_pulse_q, start_pulse_d;
  logic          stop_pulse_q, stop_pulse_d;

  assign vs_fall    =  vs_s_q[2] & ~vs_s_q[1];
  assign dwnld_fall =  dl_s_q[2] & ~dl_s_q[1];
  assign dwnld_rise = ~dl_s_q[2] &  dl_s_q[1];
  assign guard_ok   = (guard_q == GW'(GUARD));
  assign len_next   = len_q + LW'(1);

  // Bring the asynchronous vs and dwnld into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_s_q <= 3'b000;
      dl_s_q <= 3'b000;
    end else begin
      vs_s_q <= {vs_s_q[1:0], vs};
      dl_s_q <= {dl_s_q[1:0], dwnld};
    end
  end

  // Frame counter advances once per vs falling edge and wraps naturally.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (vs_fall) frame_cnt_d = frame_cnt_q + FW'(1);
  end

  // Frame counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= '0;
    else        frame_cnt_q <= frame_cnt_d;
  end

  // Guard counter saturates at GUARD; download-end triggers wait for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         guard_q <= '0;
    else if (!guard_ok) guard_q <= guard_q + GW'(1);
  end

  // Next-state logic; exit priority from ACTIVE is re-download first.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    start_d       = start_q;
    dlen_d        = dlen_q;
    len_d         = len_q;
    start_pulse_d = 1'b0;
    stop_pulse_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          mode_d  = mode_rom;
          start_d = start_frame;
          dlen_d  = dump_len;
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (!arm) begin
          state_d = ST_IDLE;
        end else if (mode_q ? (dwnld_fall && guard_ok)
                            : (vs_fall && (frame_cnt_q == start_q))) begin
          state_d       = ST_ACTIVE;
          start_pulse_d = 1'b1;
          len_d         = '0;
        end
      end
      ST_ACTIVE: begin
        if (vs_fall) len_d = len_next;
        if (mode_q && dwnld_rise) begin
          state_d      = ST_ARMED;
          stop_pulse_d = 1'b1;
        end else if (!arm ||
                     ((dlen_q != '0) && vs_fall && (len_next == dlen_q))) begin
          state_d      = ST_DONE;
          stop_pulse_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (!arm) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, latched configuration, length counter and strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      mode_q        <= 1'b0;
      start_q       <= '0;
      dlen_q        <= '0;
      len_q         <= '0;
      start_pulse_q <= 1'b0;
      stop_pulse_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      start_q       <= start_d;
      dlen_q        <= dlen_d;
      len_q         <= len_d;
      start_pulse_q <= start_pulse_d;
      stop_pulse_q  <= stop_pulse_d;
    end
  end

  assign frame_cnt  = frame_cnt_q;
  assign dump_en    = (state_q == ST_ACTIVE);
  assign dump_start = start_pulse_q;
  assign dump_stop  = stop_pulse_q;
  assign st         = state_q;

endmodule

// File: tb/tb_jtframe_dump_sched.sv
// Bench for the dump scheduler: directed scenarios push expected start/stop
// events into a queue; a negedge monitor pops and compares every event the
// DUT produces. Event encoding: {kind[1:0], st[1:0], frame_cnt[3:0]} with
// kind 01 = start, 10 = stop.
module tb_jtframe_dump_sched;

  localparam int FW = 4;
  localparam int LW = 8;
  localparam int GUARD = 16;

  logic          clk;
  logic          rst_n;
  logic          vs;
  logic          dwnld;
  logic          arm;
  logic          mode_rom;
  logic [FW-1:0] start_frame;
  logic [LW-1:0] dump_len;
  logic [FW-1:0] frame_cnt;
  logic          dump_en;
  logic          dump_start;
  logic          dump_stop;
  logic [1:0]    st;

  int n_checks;
  int n_errors;
  int mfc;  // model frame count since reset (unwrapped)
  logic [7:0] exp_q[$];

  jtframe_dump_sched #(.FW(FW), .LW(LW), .GUARD(GUARD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vs          (vs),
    .dwnld       (dwnld),
    .arm         (arm),
    .mode_rom    (mode_rom),
    .start_frame (start_frame),
    .dump_len    (dump_len),
    .frame_cnt   (frame_cnt),
    .dump_en     (dump_en),
    .dump_start  (dump_start),
    .dump_stop   (dump_stop),
    .st          (st)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ev(input logic [1:0] k, input logic [1:0] s, input int f);
    int fm;
    fm = f % 16;
    return {k, s, fm[3:0]};
  endfunction

  // Scoreboard monitor: every strobe the DUT raises must match the queue head.
  always @(negedge clk) begin
    if (dump_start || dump_stop) begin
      if (exp_q.size() == 0) check("unexpected_evt", {dump_stop, dump_start, st, frame_cnt}, 8'h00);
      else                   check("evt", {dump_stop, dump_start, st, frame_cnt}, exp_q.pop_front());
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic vs_frame(input int period);
    vs = 1'b0;
    tick(4);
    vs = 1'b1;
    mfc++;
    tick(period - 4);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    mfc = 0;
  endtask

  initial begin
    int pre;
    n_checks = 0;
    n_errors = 0;
    mfc = 0;
    rst_n = 1'b0;
    vs = 1'b1;
    dwnld = 1'b0;
    arm = 1'b0;
    mode_rom = 1'b0;
    start_frame = '0;
    dump_len = '0;

    // Reset state
    tick(2);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_dump_en", dump_en, 0);
    check("rst_dump_start", dump_start, 0);
    check("rst_dump_stop", dump_stop, 0);
    check("rst_st", st, 0);
    rst_n = 1'b1;
    tick(3);

    // Frame mode: start_frame=5, dump_len=3, 1000-cycle frames
    arm = 1'b1; mode_rom = 1'b0; start_frame = 4'd5; dump_len = 8'd3;
    tick(1);
    check("fm_armed", st, 1);
    start_frame = 4'd1; dump_len = 8'd9;  // ignored outside IDLE
    for (int i = 0; i < 11; i++) begin
      pre = mfc;
      if (pre == 5) exp_q.push_back(ev(2'b01, 2'd2, pre + 1));
      if (pre == 8) exp_q.push_back(ev(2'b10, 2'd3, pre + 1));
      vs_frame(1000);
      check("fm_dump_en", dump_en, (pre >= 5 && pre < 8) ? 1 : 0);
      check("fm_frame_cnt", frame_cnt, mfc % 16);
    end
    check("fm_done", st, 3);
    arm = 1'b0;
    tick(1);
    check("fm_idle", st, 0);
    check("fm_q_empty", exp_q.size(), 0);

    // ROM mode: early download end ignored by the guard, later one accepted
    arm = 1'b1; mode_rom = 1'b1; dwnld = 1'b1;
    do_reset();
    tick(9);
    dwnld = 1'b0;
    tick(5);
    check("rom_guard_armed", st, 1);
    check("rom_guard_en", dump_en, 0);
    tick(20);
    dwnld = 1'b1;
    tick(60);
    exp_q.push_back(ev(2'b01, 2'd2, mfc));
    dwnld = 1'b0;
    tick(2);
    check("rom_start_early", dump_start, 0);
    tick(1);
    check("rom_start_3cyc", dump_start, 1);
    check("rom_active", st, 2);

    // Re-download while active goes back to ARMED, next end re-opens
    tick(5);
    exp_q.push_back(ev(2'b10, 2'd1, mfc));
    dwnld = 1'b1;
    tick(3);
    check("redl_armed", st, 1);
    check("redl_en", dump_en, 0);
    tick(5);
    exp_q.push_back(ev(2'b01, 2'd2, mfc));
    dwnld = 1'b0;
    tick(3);
    check("redl_reopen", st, 2);
    exp_q.push_back(ev(2'b10, 2'd3, mfc));
    arm = 1'b0;
    tick(1);
    check("redl_done", st, 3);
    tick(1);
    check("redl_idle", st, 0);
    check("redl_q_empty", exp_q.size(), 0);

    // Unlimited window plus abort; frame counter wraps 15 -> 0 several times
    arm = 1'b1; mode_rom = 1'b0; start_frame = 4'd2; dump_len = 8'd0;
    tick(1);
    for (int i = 0; i < 53; i++) begin
      if (i == 2) exp_q.push_back(ev(2'b01, 2'd2, mfc + 1));
      vs_frame(40);
      check("unl_frame_cnt", frame_cnt, mfc % 16);
      check("unl_dump_en", dump_en, (i >= 2) ? 1 : 0);
    end
    exp_q.push_back(ev(2'b10, 2'd3, mfc));
    arm = 1'b0;
    tick(1);
    check("unl_done", st, 3);
    tick(1);
    check("unl_idle", st, 0);
    check("unl_q_empty", exp_q.size(), 0);

    // Arm drop on the same edge as the final-frame vs_fall: one stop only
    start_frame = 4'((mfc + 1) % 16); dump_len = 8'd2; arm = 1'b1;
    tick(1);
    for (int j = 0; j < 3; j++) begin
      pre = mfc;
      if (j == 1) exp_q.push_back(ev(2'b01, 2'd2, pre + 1));
      vs_frame(40);
    end
    pre = mfc;
    exp_q.push_back(ev(2'b10, 2'd3, pre + 1));
    vs = 1'b0;
    tick(2);
    arm = 1'b0;
    tick(1);
    check("sim_done", st, 3);
    check("sim_en", dump_en, 0);
    tick(1);
    check("sim_idle", st, 0);
    vs = 1'b1;
    mfc++;
    tick(30);
    check("sim_q_empty", exp_q.size(), 0);

    // Asynchronous reset mid-window
    start_frame = 4'(mfc % 16); dump_len = 8'd0; arm = 1'b1;
    tick(1);
    exp_q.push_back(ev(2'b01, 2'd2, mfc + 1));
    vs_frame(40);
    check("rst_win_open", dump_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_dump_en", dump_en, 0);
    check("arst_st", st, 0);
    check("arst_frame_cnt", frame_cnt, 0);
    check("arst_dump_stop", dump_stop, 0);
    check("arst_dump_start", dump_start, 0);
    arm = 1'b0;
    tick(2);
    rst_n = 1'b1;
    mfc = 0;
    tick(3);
    check("post_rst_st", st, 0);
    check("post_rst_stop", dump_stop, 0);
    check("final_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
